lpc_cycle_logger: RTL

Downstream consumer of the LPC peripheral's cycle-capture output (32-bit cycle record plus READY strobe).
- Buffers captured I/O cycle records in a FIFO.
- Formats each record as an 11-character ASCII line.
- Transmits the line over an 8N1 UART for host-side logging of the LPC bus.
- Runs on the LPC clock domain; no CDC inside the block.

---
 rtl/lpc_cycle_logger.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/lpc_cycle_logger.sv
// LPC cycle logger: buffers captured I/O cycle records and prints each one as an
// ASCII line ("W AAAA DD\r\n") over an 8N1 UART. Optional macro: LPC_LOG_OVERFLOW_MARK_EN.
module lpc_cycle_logger #(
  parameter int CLK_DIV = 4,
  parameter int FIFO_AW = 2
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  input  logic [31:0]        tdata_i,
  input  logic               ready_i,
  input  logic               clr_ovf_i,
  output logic               tx_o,
  output logic               busy_o,
  output logic [FIFO_AW:0]   fifo_level_o,
  output logic               overflow_o
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW+1)'(DEPTH);
  localparam logic [DW-1:0]    DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;

  // Stored record layout: [25:10] address, [9:2] data, [1:0] type.
  logic [25:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level;
  logic               ready_d;
  logic               overflow;

  logic [2:0]    state;
  logic [3:0]    char_idx;
  logic [3:0]    last_idx;
  logic [25:0]   rec;
  logic [7:0]    shreg;
  logic [7:0]    char_sel;
  logic [2:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic          div_end;
  logic          tx_q;

  logic push_req, do_push, do_pop, drop, full, empty;
  logic unused_bits;

  assign unused_bits = ^{tdata_i[31:28], tdata_i[3:2]};

  assign push_req = ready_i & ~ready_d;
  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign do_push  = push_req & ~full;
  assign drop     = push_req & full;
  assign do_pop   = (state == S_IDLE) & ~empty;
  assign div_end  = (div_cnt == DIV_LAST);

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= {tdata_i[27:4], tdata_i[1:0]};
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      ready_d  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      ready_d <= ready_i;
      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (FIFO_AW+1)'(1);
        2'b01:   level <= level - (FIFO_AW+1)'(1);
        default: level <= level;
      endcase
      if (drop)           overflow <= 1'b1;
      else if (clr_ovf_i) overflow <= 1'b0;
    end
  end

  function automatic logic [7:0] hex(input logic [3:0] n);
    hex = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

`ifdef LPC_LOG_OVERFLOW_MARK_EN
  logic mark, rearm, prefix;
  assign last_idx = prefix ? 4'd11 : 4'd10;

  // A drop after the pop must survive the clear at the end of the '!' so the
  // following record gets marked as well.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      mark  <= 1'b0;
      rearm <= 1'b0;
    end else begin
      if (do_pop)    rearm <= drop;
      else if (drop) rearm <= 1'b1;
      if ((state == S_STOP) && div_end && prefix && (char_idx == 4'd0))
        mark <= rearm | drop;
      else if (drop)
        mark <= 1'b1;
    end
  end
`else
  assign last_idx = 4'd10;
`endif

  always_comb begin
    logic [3:0] eidx;
    eidx = char_idx;
`ifdef LPC_LOG_OVERFLOW_MARK_EN
    if (prefix) eidx = char_idx - 4'd1;
`endif
    case (eidx)
      4'd0: begin
        case (rec[1:0])
          2'b01:   char_sel = 8'h57;
          2'b11:   char_sel = 8'h52;
          default: char_sel = 8'h3F;
        endcase
      end
      4'd1:    char_sel = 8'h20;
      4'd2:    char_sel = hex(rec[25:22]);
      4'd3:    char_sel = hex(rec[21:18]);
      4'd4:    char_sel = hex(rec[17:14]);
      4'd5:    char_sel = hex(rec[13:10]);
      4'd6:    char_sel = 8'h20;
      4'd7:    char_sel = hex(rec[9:6]);
      4'd8:    char_sel = hex(rec[5:2]);
      4'd9:    char_sel = 8'h0D;
      4'd10:   char_sel = 8'h0A;
      default: char_sel = 8'h3F;
    endcase
`ifdef LPC_LOG_OVERFLOW_MARK_EN
    if (prefix && (char_idx == 4'd0)) char_sel = 8'h21;
`endif
  end

  // tx_q is registered and changes on the same edge as the state it belongs to.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state    <= S_IDLE;
      char_idx <= '0;
      rec      <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      tx_q     <= 1'b1;
`ifdef LPC_LOG_OVERFLOW_MARK_EN
      prefix   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (do_pop) begin
            rec      <= mem[rd_ptr];
            char_idx <= '0;
            state    <= S_LOAD;
`ifdef LPC_LOG_OVERFLOW_MARK_EN
            prefix   <= mark;
`endif
          end
        end
        S_LOAD: begin
          shreg   <= char_sel;
          tx_q    <= 1'b0;
          div_cnt <= '0;
          state   <= S_START;
        end
        S_START: begin
          if (div_end) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_q    <= shreg[0];
            state   <= S_DATA;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_DATA: begin
          if (div_end) begin
            div_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx_q  <= 1'b1;
              state <= S_STOP;
            end else begin
              shreg   <= {1'b0, shreg[7:1]};
              tx_q    <= shreg[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_STOP: begin
          if (div_end) begin
            div_cnt <= '0;
            state   <= S_NEXT;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_NEXT: begin
          if (char_idx == last_idx) begin
            state <= S_IDLE;
          end else begin
            char_idx <= char_idx + 4'd1;
            state    <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign tx_o         = tx_q;
  assign busy_o       = (state != S_IDLE);
  assign fifo_level_o = level;
  assign overflow_o   = overflow;

endmodule
